// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder.
//   word_t       : 32-bit instruction / address word
//   opcode_t     : RV32I opcodes the encoder understands
//   enc_state_t  : encoder control states
//   IMM_*_MIN/MAX: legal immediate ranges per instruction format
//   in_range()   : signed inclusive range test
package instr_encoder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [6:0] {
        R_Type = 7'b0110011,
        I_Type = 7'b0010011,
        LW     = 7'b0000011,
        SW     = 7'b0100011,
        BEQ    = 7'b1100011,
        J      = 7'b1101111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } enc_state_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer.
// Ports:
//   i_opcode/i_rd/i_rs1/i_rs2/i_funct3/i_funct7/i_imm : instruction fields
//   o_word    : packed 32-bit instruction
//   o_illegal : immediate out of range, odd branch/jump offset, or unknown opcode
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output word_t       o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (opcode_t'(i_opcode))
            R_Type: begin
                o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            I_Type, LW: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_illegal = !in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
            end
            SW: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_illegal = !in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
            end
            BEQ: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                // Branch targets are halfword aligned; bit 0 is not encodable.
                o_illegal = !in_range(i_imm, IMM_B_MIN, IMM_B_MAX) || i_imm[0];
            end
            J: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_illegal = !in_range(i_imm, IMM_J_MIN, IMM_J_MAX) || i_imm[0];
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requested fields into RV32I words and streams
// them into instruction memory at incrementing word addresses.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, finish       : begin program (IDLE/FULL) / end program (RUN)
//   in_valid, in_ready  : request handshake
//   in_opcode..in_imm   : instruction fields
//   imem_we, imem_ready : memory write handshake
//   imem_addr, imem_wdata : write address / encoded word
//   word_count, err_count : words written / requests dropped this program
//   busy, done          : not idle / end-of-program pulse
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       finish,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [31:0]                in_imm,
    output logic                       imem_we,
    input  logic                       imem_ready,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic [15:0]                err_count,
    output logic                       busy,
    output logic                       done
);

    localparam int                WC_W     = $clog2(DEPTH + 1);
    localparam logic [31:0]       DEPTH_W  = 32'(DEPTH);
    localparam logic [WC_W-1:0]   LAST_IDX = WC_W'(DEPTH - 1);

    enc_state_t      r_state;
    enc_state_t      w_state_next;
    logic            w_done_next;
    logic            r_s1_valid;
    word_t           r_wdata;
    word_t           r_addr;
    logic [WC_W-1:0] r_word_count;
    logic [15:0]     r_err_count;
    logic            r_done;

    word_t           w_word;
    logic            w_illegal;
    logic            w_wr_done;
    logic            w_accept;
    logic            w_start_ok;
    logic            w_room;
    logic [31:0]     w_occupancy;

    instr_pack u_pack (
        .i_opcode  (in_opcode),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_funct3  (in_funct3),
        .i_funct7  (in_funct7),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_wr_done   = r_s1_valid && imem_ready;
    // Count the word still in s1 so the final slot is never over-committed.
    assign w_occupancy = 32'(r_word_count) + 32'(r_s1_valid);
    assign w_room      = w_occupancy < DEPTH_W;
    assign in_ready    = (r_state == RUN) && (!r_s1_valid || w_wr_done) && w_room;
    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == FULL));

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                if (w_wr_done && (r_word_count == LAST_IDX)) begin
                    w_state_next = FULL;
                    w_done_next  = 1'b1;
                end else if (finish) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_s1_valid) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            FULL: begin
                if (start) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_s1_valid   <= 1'b0;
            r_wdata      <= '0;
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_start_ok) begin
                r_addr       <= BASE_ADDR;
                r_word_count <= '0;
                r_err_count  <= '0;
            end else begin
                if (w_wr_done) begin
                    r_addr       <= r_addr + 32'd4;
                    r_word_count <= r_word_count + WC_W'(1);
                end
                if (w_accept && w_illegal && (r_err_count != 16'hFFFF)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end

            // A legal accept refills s1 in the same cycle the old word drains.
            if (w_accept && !w_illegal) begin
                r_s1_valid <= 1'b1;
                r_wdata    <= w_word;
            end else if (w_wr_done) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign imem_we    = r_s1_valid;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_word_count;
    assign err_count  = r_err_count;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a DEPTH=256 instance for encoding,
// error, stall, finish and reset behaviour, and a DEPTH=4 instance for FULL.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;

    logic        a_in_ready, a_we, a_busy, a_done;
    logic [31:0] a_addr, a_wdata;
    logic [8:0]  a_wc;
    logic [15:0] a_err;
    logic        b_in_ready, b_we, b_busy, b_done;
    logic [31:0] b_addr, b_wdata;
    logic [2:0]  b_wc;
    logic [15:0] b_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(256)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(a_we),
        .imem_ready(imem_ready), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .word_count(a_wc), .err_count(a_err), .busy(a_busy), .done(a_done)
    );

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(b_we),
        .imem_ready(imem_ready), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .word_count(b_wc), .err_count(b_err), .busy(b_busy), .done(b_done)
    );

    // Write logs, sampled mid-cycle: a write completes at the next rising edge.
    word_t a_log_data[$];
    word_t a_log_addr[$];
    word_t b_log_addr[$];
    int    b_log_cyc[$];
    int    cyc = 0;
    bit    b_done_seen = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && a_we && imem_ready) begin
            a_log_data.push_back(a_wdata);
            a_log_addr.push_back(a_addr);
            $display("A write addr=%h data=%h", a_addr, a_wdata);
        end
        if (!rst && b_we && imem_ready) begin
            b_log_addr.push_back(b_addr);
            b_log_cyc.push_back(cyc);
            $display("B write addr=%h data=%h", b_addr, b_wdata);
        end
        if (b_done) b_done_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to instance A and hold it until accepted.
    task automatic send_a(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3v,
                          input logic [6:0] f7v, input logic [31:0] iv);
        bit got = 1'b0;
        in_opcode = o; in_rd = d; in_rs1 = s1; in_rs2 = s2;
        in_funct3 = f3v; in_funct7 = f7v; in_imm = iv;
        in_valid  = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (a_in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("accept", 32'(got), 32'd1);
    endtask

    // Legal request: word appears in s1 at the expected address, then writes.
    task automatic send_word(input string tag, input logic [6:0] o, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2,
                             input logic [2:0] f3v, input logic [31:0] iv,
                             input logic [31:0] exp_word, input logic [31:0] exp_addr);
        send_a(o, d, s1, s2, f3v, 7'd0, iv);
        chk({tag, "_we"}, 32'(a_we), 32'd1);
        chk({tag, "_wdata"}, a_wdata, exp_word);
        chk({tag, "_addr"}, a_addr, exp_addr);
        tick();
        chk({tag, "_count"}, 32'(a_wc), (exp_addr >> 2) + 32'd1);
        $display("txn %s word=%h addr=%h", tag, exp_word, exp_addr);
    endtask

    task automatic send_bad(input string tag, input logic [6:0] o, input logic [31:0] iv);
        send_a(o, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, iv);
        chk({tag, "_no_we"}, 32'(a_we), 32'd0);
        $display("txn %s dropped err_count=%0d", tag, a_err);
    endtask

    initial begin
        word_t exp_data [7];
        int    n_acc;
        bit    b_ok;

        exp_data = '{32'h00500093, 32'hFE112E23, 32'hFE208CE3, 32'h0010006F,
                     32'h002081B3, 32'h00100113, 32'hFFF00213};

        // Reset values
        tick(); tick();
        rst = 1'b0;
        chk("rst_we", 32'(a_we), 32'd0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        chk("rst_count", 32'(a_wc), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);

        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", 32'(a_busy), 32'd1);
        chk("start_in_ready", 32'(a_in_ready), 32'd1);

        // Encodings
        send_word("i_type", I_Type, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 32'h0);
        send_word("sw", SW, 5'd0, 5'd2, 5'd1, 3'd2, -32'sd4, 32'hFE112E23, 32'h4);
        send_word("beq", BEQ, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 32'hFE208CE3, 32'h8);
        send_word("jal", J, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0010006F, 32'hC);

        // Illegal requests are consumed but never written
        send_bad("i_imm_2048", I_Type, 32'd2048);
        send_bad("beq_odd", BEQ, 32'd3);
        send_bad("bad_opcode", 7'h7F, 32'd0);
        chk("err_count", 32'(a_err), 32'd3);
        chk("err_addr", a_addr, 32'h10);
        chk("err_words", 32'(a_wc), 32'd4);

        // Memory stall with the next request already waiting
        imem_ready = 1'b0;
        send_a(R_Type, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
        chk("stall_we", 32'(a_we), 32'd1);
        in_opcode = I_Type; in_rd = 5'd2; in_rs1 = 5'd0; in_imm = 32'd1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", 32'(a_in_ready), 32'd0);
            chk("stall_wdata", a_wdata, 32'h002081B3);
            chk("stall_addr", a_addr, 32'h10);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_wdata", a_wdata, 32'h00100113);
        chk("b2b_addr", a_addr, 32'h14);
        chk("b2b_count", 32'(a_wc), 32'd5);
        tick();
        chk("b2b_done_addr", a_addr, 32'h18);
        chk("b2b_done_count", 32'(a_wc), 32'd6);
        $display("txn stall: R word and I word written once each");

        // finish with a word still pending
        imem_ready = 1'b0;
        send_a(I_Type, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        finish = 1'b1; tick(); finish = 1'b0;
        chk("drain_busy", 32'(a_busy), 32'd1);
        chk("drain_we", 32'(a_we), 32'd1);
        chk("drain_in_ready", 32'(a_in_ready), 32'd0);
        imem_ready = 1'b1;
        for (int k = 0; k < 10 && !a_done; k++) tick();
        chk("drain_done", 32'(a_done), 32'd1);
        chk("drain_idle", 32'(a_busy), 32'd0);
        chk("drain_count", 32'(a_wc), 32'd7);
        tick();
        chk("done_pulse", 32'(a_done), 32'd0);
        $display("txn finish: drained to idle with %0d words", a_wc);

        // New program, then reset during a stalled write
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_addr", a_addr, 32'h0);
        chk("restart_count", 32'(a_wc), 32'd0);
        chk("restart_err", 32'(a_err), 32'd0);
        imem_ready = 1'b0;
        send_a(J, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        chk("pend_we", 32'(a_we), 32'd1);
        chk("pend_wdata", a_wdata, 32'h000000EF);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_we", 32'(a_we), 32'd0);
        chk("mrst_wdata", a_wdata, 32'h0);
        chk("mrst_addr", a_addr, 32'h0);
        chk("mrst_busy", 32'(a_busy), 32'd0);
        chk("mrst_in_ready", 32'(a_in_ready), 32'd0);
        chk("mrst_done", 32'(a_done), 32'd0);
        $display("txn reset during stalled write");

        // Exactly the seven legal words, in order, at consecutive addresses
        chk("log_size", 32'(a_log_data.size()), 32'd7);
        for (int i = 0; i < 7 && i < a_log_data.size(); i++) begin
            chk($sformatf("log_data%0d", i), a_log_data[i], exp_data[i]);
            chk($sformatf("log_addr%0d", i), a_log_addr[i], 32'(i * 4));
        end

        // DEPTH=4 instance: six back-to-back requests
        imem_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        b_done_seen = 1'b0;
        b_log_addr.delete();
        b_log_cyc.delete();
        n_acc = 0;
        in_opcode = I_Type; in_rs1 = 5'd0; in_rd = 5'd1; in_imm = 32'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            b_ok = b_in_ready && (n_acc < 6);
            tick();
            if (b_ok) begin
                n_acc  = n_acc + 1;
                in_rd  = 5'(n_acc + 1);
                in_imm = 32'(n_acc);
                if (n_acc == 6) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("full_accepts", 32'(n_acc), 32'd4);
        chk("full_writes", 32'(b_log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < b_log_addr.size(); i++) begin
            chk($sformatf("full_addr%0d", i), b_log_addr[i], 32'(i * 4));
            chk($sformatf("full_cyc%0d", i), 32'(b_log_cyc[i] - b_log_cyc[0]), 32'(i));
        end
        chk("full_done", 32'(b_done_seen), 32'd1);
        chk("full_busy", 32'(b_busy), 32'd1);
        chk("full_in_ready", 32'(b_in_ready), 32'd0);
        chk("full_count", 32'(b_wc), 32'd4);
        $display("txn full: %0d accepted, %0d written", n_acc, b_log_addr.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
